// File: rtl/univgates_checker.sv
// -----------------------------------------------------------------------------
// univgates_checker
//
// Response checker for a universal-gate block (NAND/NOR/NOT/XNOR/XOR).
// Each accepted vector carries the applied inputs {A,B} and the five outputs
// observed on the gate block. The checker computes the golden outputs and
// counts mismatching vectors. It captures the first failing vector, and after
// VEC_COUNT vectors it raises a registered pass/fail verdict.
//
// Ports
//   clk             system clock, rising edge
//   rst_n           synchronous active-low reset
//   start           one-cycle pulse: clear results and begin a run
//   in_valid        in_* fields form one vector (accepted only in RUN)
//   in_a, in_b      applied inputs A and B
//   in_nand .. in_xor  observed gate outputs
//   busy            high while in RUN
//   done            high while in DONE
//   pass            valid while done; 1 = no mismatching vector in the run
//   err_count       mismatching vectors this run (saturating)
//   vec_count       vectors accepted this run
//   first_fail_idx  vec_count value of the first failing vector
//   first_fail_mask {nand,nor,not,xnor,xor} mismatch bits of that vector
//   first_fail_ab   {A,B} of that vector
//   dbg_state       current FSM state (0 IDLE, 1 RUN, 2 DONE) for checkers
//
// Handshake: the stream has no backpressure. A vector is consumed in any cycle
// where in_valid=1, the FSM is in RUN and start=0. Vectors presented in any
// other cycle are dropped silently.
// -----------------------------------------------------------------------------
module univgates_checker #(
    parameter int VEC_COUNT = 4,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic             in_a,
    input  logic             in_b,
    input  logic             in_nand,
    input  logic             in_nor,
    input  logic             in_not,
    input  logic             in_xnor,
    input  logic             in_xor,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [4:0]       first_fail_mask,
    output logic [1:0]       first_fail_ab,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_COUNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] ERR_MAX  = '1;

    state_e           state_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [CNT_W-1:0] err_count_q;
    logic [CNT_W-1:0] vec_count_q;
    logic [CNT_W-1:0] ff_idx_q;
    logic [4:0]       ff_mask_q;
    logic [1:0]       ff_ab_q;

    logic [4:0]       exp_vec;
    logic [4:0]       obs_vec;
    logic [4:0]       mism;
    logic             has_err;
    logic             accept;
    logic             is_last;
    logic [CNT_W-1:0] err_count_d;
    logic [CNT_W-1:0] vec_count_d;

    // Golden model and per-vector bookkeeping. The bit order is
    // {nand,nor,not,xnor,xor}.
    always_comb begin
        exp_vec     = {~(in_a & in_b), ~(in_a | in_b), ~in_a, ~(in_a ^ in_b), in_a ^ in_b};
        obs_vec     = {in_nand, in_nor, in_not, in_xnor, in_xor};
        mism        = obs_vec ^ exp_vec;
        has_err     = |mism;
        accept      = (state_q == ST_RUN) && in_valid && !start;
        is_last     = (vec_count_q == LAST_IDX);
        vec_count_d = vec_count_q + CNT_ONE;
        // Saturate so a long failing run cannot wrap back to zero, which
        // would turn into a false pass.
        err_count_d = (has_err && (err_count_q != ERR_MAX)) ? (err_count_q + CNT_ONE)
                                                            : err_count_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_count_q <= '0;
            vec_count_q <= '0;
            ff_idx_q    <= '0;
            ff_mask_q   <= '0;
            ff_ab_q     <= '0;
        end else if (start) begin
            // start has priority over in_valid in every state, including RUN,
            // where it restarts the run.
            state_q     <= ST_RUN;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_count_q <= '0;
            vec_count_q <= '0;
            ff_idx_q    <= '0;
            ff_mask_q   <= '0;
            ff_ab_q     <= '0;
        end else if (accept) begin
            vec_count_q <= vec_count_d;
            err_count_q <= err_count_d;
            // Capture only on the first failure. err_count_q is the count
            // before this vector.
            if (has_err && (err_count_q == '0)) begin
                ff_idx_q  <= vec_count_q;
                ff_mask_q <= mism;
                ff_ab_q   <= {in_a, in_b};
            end
            if (is_last) begin
                state_q <= ST_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                pass_q  <= (err_count_d == '0);
            end
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_count       = err_count_q;
    assign vec_count       = vec_count_q;
    assign first_fail_idx  = ff_idx_q;
    assign first_fail_mask = ff_mask_q;
    assign first_fail_ab   = ff_ab_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_univgates_checker.sv
// -----------------------------------------------------------------------------
// tb_univgates_checker
//
// Directed bench for univgates_checker with VEC_COUNT=4 and CNT_W=8. Inputs are
// driven 1 ns after the rising edge, and outputs are sampled at the same point
// in the next cycle. The golden gate outputs for each {A,B} pair come from a
// hand-written table. Fault injection XORs a flip mask onto the good outputs,
// so the expected first_fail_mask is the flip mask itself.
// -----------------------------------------------------------------------------
module tb_univgates_checker;

    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             in_valid;
    logic             in_a;
    logic             in_b;
    logic             in_nand;
    logic             in_nor;
    logic             in_not;
    logic             in_xnor;
    logic             in_xor;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] vec_count;
    logic [CNT_W-1:0] first_fail_idx;
    logic [4:0]       first_fail_mask;
    logic [1:0]       first_fail_ab;
    logic [1:0]       dbg_state;

    int n_checks;
    int n_pass;

    univgates_checker #(
        .VEC_COUNT(4),
        .CNT_W    (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .in_valid       (in_valid),
        .in_a           (in_a),
        .in_b           (in_b),
        .in_nand        (in_nand),
        .in_nor         (in_nor),
        .in_not         (in_not),
        .in_xnor        (in_xnor),
        .in_xor         (in_xor),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .vec_count      (vec_count),
        .first_fail_idx (first_fail_idx),
        .first_fail_mask(first_fail_mask),
        .first_fail_ab  (first_fail_ab),
        .dbg_state      (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic b, input logic d, input logic p,
                             input int err, input int vec, input int idx,
                             input logic [4:0] mask, input logic [1:0] ab);
        check({tag, ".busy"}, 32'(b), 32'(busy));
        check({tag, ".done"}, 32'(done), 32'(d));
        check({tag, ".pass"}, 32'(pass), 32'(p));
        check({tag, ".err_count"}, 32'(err_count), 32'(err));
        check({tag, ".vec_count"}, 32'(vec_count), 32'(vec));
        check({tag, ".ff_idx"}, 32'(first_fail_idx), 32'(idx));
        check({tag, ".ff_mask"}, 32'(first_fail_mask), 32'(mask));
        check({tag, ".ff_ab"}, 32'(first_fail_ab), 32'(ab));
    endtask

    // Hand-computed {nand,nor,not,xnor,xor} for each {A,B}.
    function automatic logic [4:0] good_out(input logic [1:0] ab);
        case (ab)
            2'b00:   good_out = 5'b11110;
            2'b01:   good_out = 5'b10101;
            2'b11:   good_out = 5'b00010;
            default: good_out = 5'b10001; // 2'b10
        endcase
    endfunction

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_vec(input logic [1:0] ab, input logic [4:0] flip);
        logic [4:0] o;
        o        = good_out(ab) ^ flip;
        in_valid = 1'b1;
        {in_a, in_b} = ab;
        {in_nand, in_nor, in_not, in_xnor, in_xor} = o;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        {in_a, in_b} = 2'b00;
        {in_nand, in_nor, in_not, in_xnor, in_xor} = 5'b00000;
    endtask

    task automatic send_vec(input logic [1:0] ab, input logic [4:0] flip);
        drive_vec(ab, flip);
        tick();
        idle_inputs();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic good_run();
        send_vec(2'b00, 5'b0);
        send_vec(2'b01, 5'b0);
        send_vec(2'b11, 5'b0);
        send_vec(2'b10, 5'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        idle_inputs();
        tick();
        tick();
        check_all("reset", 1'b0, 1'b0, 1'b0, 0, 0, 0, 5'b0, 2'b0);
        check("reset.state", 32'(dbg_state), 32'd0);
        rst_n = 1'b1;

        // in_valid while IDLE is dropped.
        send_vec(2'b01, 5'b00001);
        check_all("idle_valid", 1'b0, 1'b0, 1'b0, 0, 0, 0, 5'b0, 2'b0);

        // start together with in_valid: start wins and the vector is dropped.
        drive_vec(2'b11, 5'b10000);
        start = 1'b1;
        tick();
        start = 1'b0;
        idle_inputs();
        check_all("start_valid", 1'b1, 1'b0, 1'b0, 0, 0, 0, 5'b0, 2'b0);
        check("start_valid.state", 32'(dbg_state), 32'd1);

        // Test 1: clean run; done comes exactly one cycle after the 4th vector.
        send_vec(2'b00, 5'b0);
        send_vec(2'b01, 5'b0);
        send_vec(2'b11, 5'b0);
        check("t1.vec3", 32'(vec_count), 32'd3);
        check("t1.not_done_yet", 32'(done), 32'd0);
        send_vec(2'b10, 5'b0);
        check_all("t1", 1'b0, 1'b1, 1'b1, 0, 4, 0, 5'b0, 2'b0);
        check("t1.state", 32'(dbg_state), 32'd2);

        // in_valid in DONE (including a bad vector) is dropped; DONE holds.
        send_vec(2'b11, 5'b11111);
        tick();
        check_all("done_valid", 1'b0, 1'b1, 1'b1, 0, 4, 0, 5'b0, 2'b0);

        // Test 2: nand wrong at index 2 (AB=11).
        pulse_start();
        send_vec(2'b00, 5'b0);
        send_vec(2'b01, 5'b0);
        send_vec(2'b11, 5'b10000);
        send_vec(2'b10, 5'b0);
        check_all("t2", 1'b0, 1'b1, 1'b0, 1, 4, 2, 5'b10000, 2'b11);

        // Test 3: xor wrong at index 1, not wrong at index 3; first capture kept.
        pulse_start();
        send_vec(2'b00, 5'b0);
        send_vec(2'b01, 5'b00001);
        send_vec(2'b11, 5'b0);
        send_vec(2'b10, 5'b00100);
        check_all("t3", 1'b0, 1'b1, 1'b0, 2, 4, 1, 5'b00001, 2'b01);

        // Test 5: restart mid-run after one failure, then a fresh clean run.
        pulse_start();
        send_vec(2'b00, 5'b0);
        send_vec(2'b01, 5'b01000);
        check_all("t5.mid", 1'b1, 1'b0, 1'b0, 1, 2, 1, 5'b01000, 2'b01);
        pulse_start();
        check_all("t5.restart", 1'b1, 1'b0, 1'b0, 0, 0, 0, 5'b0, 2'b0);
        good_run();
        check_all("t5.final", 1'b0, 1'b1, 1'b1, 0, 4, 0, 5'b0, 2'b0);

        // Test 6: reset mid-run at vec_count=3 aborts; later vectors are dropped.
        pulse_start();
        send_vec(2'b00, 5'b0);
        send_vec(2'b01, 5'b00010);
        send_vec(2'b11, 5'b0);
        check_all("t6.mid", 1'b1, 1'b0, 1'b0, 1, 3, 1, 5'b00010, 2'b01);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_all("t6.reset", 1'b0, 1'b0, 1'b0, 0, 0, 0, 5'b0, 2'b0);
        check("t6.state", 32'(dbg_state), 32'd0);
        send_vec(2'b10, 5'b00100);
        check_all("t6.after", 1'b0, 1'b0, 1'b0, 0, 0, 0, 5'b0, 2'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
